output_port: RTL and testbench



---
 rtl/noc_pkg.sv | 21 ++
 rtl/rr_arbiter4.sv | 35 +++
 rtl/output_port.sv | 98 +++++++++
 tb/tb_output_port.sv | 126 ++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared switch definitions: flit field layout and port index type.
package noc_pkg;

    localparam int DATA_W    = 14;
    localparam int PAYLOAD_W = 12;
    localparam int VALID_BIT = 13;
    localparam int LAST_BIT  = 12;

    typedef logic [1:0] port_idx_t;

    // Encode a one-hot 4-bit grant into a port index (0 when empty)
    function automatic port_idx_t oneHotToIdx(input logic [3:0] oneHot);
        port_idx_t idx;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (oneHot[k]) idx = port_idx_t'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with packet lock override.
module rr_arbiter4
    import noc_pkg::*;
(
    input  logic [3:0] req,
    input  port_idx_t  rrPtr,
    input  logic       lockValid,
    input  port_idx_t  lockOwner,
    output logic [3:0] grant,
    output logic       grantValid
);

    // While locked only the owner may win; otherwise scan upward from rrPtr
    always_comb begin
        port_idx_t idx;
        grant      = '0;
        grantValid = 1'b0;
        idx        = '0;
        if (lockValid) begin
            if (req[lockOwner]) begin
                grant[lockOwner] = 1'b1;
                grantValid       = 1'b1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                idx = rrPtr + port_idx_t'(i);
                if (!grantValid && req[idx]) begin
                    grant[idx] = 1'b1;
                    grantValid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/output_port.sv
// Switch output port: arbitrates four inputs, locks for multi-flit packets,
// and registers the winning payload onto the output link.
module output_port
    import noc_pkg::*;
#(
    parameter int dataWidth = DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [dataWidth-1:0] data1,
    input  logic [dataWidth-1:0] data2,
    input  logic [dataWidth-1:0] data3,
    input  logic [dataWidth-1:0] data4,
    output logic                 portBlock1,
    output logic                 portBlock2,
    output logic                 portBlock3,
    output logic                 portBlock4,
    output logic [dataWidth-3:0] outputData
);

    localparam int payloadW = dataWidth - 2;

    logic [3:0][dataWidth-1:0] flits;
    logic [3:0]                req;
    logic [3:0]                grant;
    logic                      grantValid;
    logic                      winValid;
    port_idx_t                 winIdx;
    logic [payloadW-1:0]       winPayload;
    logic                      winLast;

    logic                      lockValid;
    port_idx_t                 lockOwner;
    port_idx_t                 rrPtr;
    logic [3:0]                blocked;

    assign flits = {data4, data3, data2, data1};

    // Request vector is the valid bit of each flit
    always_comb begin
        req = '0;
        for (int k = 0; k < 4; k++) req[k] = flits[k][dataWidth-1];
    end

    rr_arbiter4 uArb (
        .req        (req),
        .rrPtr      (rrPtr),
        .lockValid  (lockValid),
        .lockOwner  (lockOwner),
        .grant      (grant),
        .grantValid (grantValid)
    );

    // Nothing is accepted while reset is held, so every requester is blocked
    assign winValid = grantValid & ~reset;
    assign winIdx   = oneHotToIdx(grant);

    // One-hot payload/last mux for the granted input
    always_comb begin
        winPayload = '0;
        winLast    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (grant[k]) begin
                winPayload = winPayload | flits[k][payloadW-1:0];
                winLast    = winLast | flits[k][dataWidth-2];
            end
        end
    end

    // Back-pressure: valid and not the accepted winner
    assign blocked    = req & ~(grant & {4{winValid}});
    assign portBlock1 = blocked[0];
    assign portBlock2 = blocked[1];
    assign portBlock3 = blocked[2];
    assign portBlock4 = blocked[3];

    // Output register, packet lock and round-robin pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            outputData <= '0;
            lockValid  <= 1'b0;
            lockOwner  <= '0;
            rrPtr      <= '0;
        end else if (winValid) begin
            outputData <= winPayload;
            if (winLast) begin
                lockValid <= 1'b0;
                rrPtr     <= winIdx + 2'd1;
            end else begin
                lockValid <= 1'b1;
                lockOwner <= winIdx;
            end
        end else begin
            outputData <= '0;
        end
    end

endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port: arbitration, locking, back-pressure, reset.
module tb_output_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] data1, data2, data3, data4;
    logic        portBlock1, portBlock2, portBlock3, portBlock4;
    logic [11:0] outputData;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    output_port #(.dataWidth(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .data4      (data4),
        .portBlock1 (portBlock1),
        .portBlock2 (portBlock2),
        .portBlock3 (portBlock3),
        .portBlock4 (portBlock4),
        .outputData (outputData)
    );

    function automatic logic [13:0] fl(input logic v, input logic l, input logic [11:0] p);
        return {v, l, p};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check blocks mid-cycle, clock once, then check the registered payload
    task automatic step(input string tag, input logic [3:0] expBlk, input logic [11:0] expOut);
        #1;
        chk({tag, ".blk"}, {8'h0, portBlock4, portBlock3, portBlock2, portBlock1}, {8'h0, expBlk});
        @(posedge clk);
        #1;
        chk({tag, ".out"}, outputData, expOut);
    endtask

    task automatic setIn(input logic [13:0] a, input logic [13:0] b,
                         input logic [13:0] c, input logic [13:0] d);
        data1 = a; data2 = b; data3 = c; data4 = d;
    endtask

    initial begin
        reset = 1'b1;
        setIn('0, '0, '0, '0);
        @(posedge clk); #1;
        step("rst", 4'b0000, 12'h000);
        reset = 1'b0;

        // Case 1: input 1 wins from pointer 0 and locks
        setIn(14'b10011000101000, 14'b10111010010110, '0, 14'b10100010000001);
        step("c1", 4'b1010, 12'h628);
        data1 = fl(1, 0, 12'h123);
        step("c1lock", 4'b1010, 12'h123);

        // Case 2: tail releases lock, pointer moves to input 2
        data1 = fl(1, 1, 12'h0AB);
        step("c2tail", 4'b1010, 12'h0AB);
        data1 = '0;
        step("c2next", 4'b1000, 12'hE96);
        data2 = fl(1, 1, 12'h456);
        step("c2tail2", 4'b1000, 12'h456);
        data2 = '0;
        step("c2in4", 4'b0000, 12'h881);
        data4 = fl(1, 1, 12'h882);
        step("c2in4t", 4'b0000, 12'h882);

        // Case 3: all single-flit, grants rotate 1,2,3,4,1
        setIn(fl(1, 1, 12'h111), fl(1, 1, 12'h222), fl(1, 1, 12'h333), fl(1, 1, 12'h444));
        step("c3g1", 4'b1110, 12'h111);
        step("c3g2", 4'b1101, 12'h222);
        step("c3g3", 4'b1011, 12'h333);
        step("c3g4", 4'b0111, 12'h444);
        step("c3g1b", 4'b1110, 12'h111);

        // Case 4: locked owner idles, input 4 waits behind it
        setIn('0, '0, fl(1, 0, 12'h3A0), '0);
        step("c4head", 4'b0000, 12'h3A0);
        setIn('0, '0, '0, fl(1, 1, 12'h4B0));
        step("c4idle1", 4'b1000, 12'h000);
        step("c4idle2", 4'b1000, 12'h000);
        data3 = fl(1, 1, 12'h3A1);
        step("c4tail", 4'b1000, 12'h3A1);
        data3 = '0;
        step("c4in4", 4'b0000, 12'h4B0);

        // Zero payload is a real flit and still advances the pointer
        setIn(fl(1, 1, 12'h000), '0, '0, fl(1, 1, 12'h4B0));
        step("zpay", 4'b1000, 12'h000);
        step("zpayNext", 4'b0001, 12'h4B0);

        // Case 5: reset mid-packet with pointer at 1 and lock on input 2
        setIn(fl(1, 1, 12'h5A5), '0, '0, '0);
        step("c5a", 4'b0000, 12'h5A5);
        setIn(fl(1, 0, 12'h5A6), fl(1, 0, 12'h5B5), '0, '0);
        step("c5b", 4'b0001, 12'h5B5);
        reset = 1'b1;
        data3 = fl(1, 0, 12'h5C0);
        step("c5rst1", 4'b0111, 12'h000);
        step("c5rst2", 4'b0111, 12'h000);
        reset = 1'b0;
        setIn(fl(1, 1, 12'h5A7), fl(1, 0, 12'h5B6), fl(1, 0, 12'h5C0), '0);
        step("c5after", 4'b0110, 12'h5A7);

        // Case 6: no requests
        setIn('0, '0, '0, '0);
        step("c6a", 4'b0000, 12'h000);
        step("c6b", 4'b0000, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
